i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
//
// PURPOSE
// I2S master transmitter: takes parallel stereo PCM samples over a valid/ready handshake and
// serialises them onto the I2S bus driving HDMI_TX_I2S_BCK/WS/DATA.
// Sits between the audio processing path (volume scaling from BTN_volminus/plus) and the HDMI
// transmitter, replacing the raw I2S passthrough.
// Generates BCK and WS from a single system clock. Holds one sample pair in reserve.
//
// PARAMETERS
// SAMPLE_WIDTH  16  bits per channel sample; must be < SLOT_BITS
// SLOT_BITS     32  BCK periods per channel slot; frame length = 2*SLOT_BITS BCK periods
// BCK_HALF      4   clk cycles per BCK half-period (>=1); e.g. 24.576 MHz clk -> 3.072 MHz BCK
//
// PORTS
// clk          in   1             system clock; all logic on posedge
// reset        in   1             synchronous, active-high reset
// s_left       in   SAMPLE_WIDTH  left sample, two's complement
// s_right      in   SAMPLE_WIDTH  right sample, two's complement
// s_valid      in   1             sample pair valid
// s_ready      out  1             holding register empty; transfer when s_valid && s_ready
// i2s_bck      out  1             bit clock
// i2s_ws       out  1             word select; 0 = left, 1 = right
// i2s_data     out  1             serial data, MSB first, changes on BCK falling edge
// frame_start  out  1             1-clk pulse when frame bit 0 begins
// underrun     out  1             1-clk pulse when a frame starts with no sample held
//
// BEHAVIOUR
// - Reset (sync, active-high, one clk):
//   - bck=0, ws=0, data=0, frame_start=0, underrun=0, s_ready=1
//   - hold empty; shift regs 0; div_cnt=0; bit_cnt=2*SLOT_BITS-1.
//   - Asserting reset mid-frame aborts the frame immediately; a held sample is discarded.
// - Divider:
//   - div_cnt counts 0..BCK_HALF-1; at terminal count bck toggles and div_cnt wraps to 0.
//   - After reset: first rising edge after BCK_HALF clk, first falling edge after 2*BCK_HALF clk.
// - Falling-edge clk (bck 1->0):
//   - bit_cnt advances, wrapping 2*SLOT_BITS-1 -> 0; ws/data update on the same clk edge.
//   - ws = (bit_cnt >= SLOT_BITS); WS therefore leads the MSB by one BCK (I2S delay).
//   - Left slot: data at b = 1..SAMPLE_WIDTH is left[SAMPLE_WIDTH-b]; 0 elsewhere in b = 0..SLOT_BITS-1.
//   - Right slot: same rule applied with b-SLOT_BITS, using right.
// - Frame load (falling edge entering b=0):
//   - If hold valid: copy hold -> shift regs, clear hold.
//   - Else: shift regs = 0, and underrun pulses that clk.
//   - frame_start pulses that clk in either case.
// - Handshake:
//   - s_ready = !hold_valid, registered.
//   - Accept captures s_left/s_right into hold; s_ready goes 0 on the next clk.
//   - Load and accept cannot coincide, since s_ready=0 whenever hold is valid; s_ready returns 1 the clk after load.
//   - s_valid while s_ready=0 is ignored; the source must hold its data.
// - Throughput: one pair per frame (2*SLOT_BITS*2*BCK_HALF clk); max acceptance latency = one frame.
// - Width rule: unused slot bits transmit 0; no sign extension.
//
// TESTING
// 1. Load L=16'hA5F0, R=16'h0F5A; defaults -> frame bits 1..16 = A5F0 MSB-first, ws=0 for b<32,
//    bits 33..48 = 0F5A, other bits 0.
// 2. No s_valid after reset -> underrun pulse at every frame_start (every 512 clk); data stays 0.
// 3. s_valid held high with incrementing samples -> one accept per 512 clk; no underrun;
//    s_ready high for 1 clk after each load until the next accept.
// 4. Reset asserted at b=20 with hold full -> next clk bck=ws=data=0, s_ready=1;
//    first falling edge 8 clk after reset release.
// 5. BCK_HALF=1, SLOT_BITS=17, SAMPLE_WIDTH=16 -> bck toggles every clk; L=16'h8001 gives data
//    1 at b=1 and b=16 only.
// 6. s_valid asserted on the load clk -> not accepted that clk; accepted the next clk, sent in the following frame.

Source files
------------

// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx_if
// Brief   : Stereo sample handshake plus I2S serial bus for i2s_tx
// Revision: 1.0
// ============================================================================
interface i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] s_left;
  logic [SAMPLE_WIDTH-1:0] s_right;
  logic                    s_valid;
  logic                    s_ready;
  logic                    i2s_bck;
  logic                    i2s_ws;
  logic                    i2s_data;
  logic                    frame_start;
  logic                    underrun;

  modport master (
    output s_left, s_right, s_valid,
    input  s_ready, i2s_bck, i2s_ws, i2s_data, frame_start, underrun
  );

  modport slave (
    input  s_left, s_right, s_valid,
    output s_ready, i2s_bck, i2s_ws, i2s_data, frame_start, underrun
  );
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx
// Brief   : I2S master transmitter; BCK/WS from clk, one sample pair held
// Revision: 1.0
// ============================================================================
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int BCK_HALF     = 4
) (
  input  logic    clk,
  input  logic    reset,
  i2s_tx_if.slave bus_io
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(BCK_HALF - 1);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] c_SLOT     = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] c_L_FIRST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_L_LAST   = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] c_R_FIRST  = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] c_R_LAST   = CNT_W'(SLOT_BITS + SAMPLE_WIDTH);

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    bck_q, bck_d;
  logic                    ws_q, ws_d;
  logic                    data_q, data_d;
  logic [CNT_W-1:0]        bit_q, bit_d;
  logic [SAMPLE_WIDTH-1:0] lsh_q, lsh_d;
  logic [SAMPLE_WIDTH-1:0] rsh_q, rsh_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    ready_q, ready_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;

  logic                    w_bck_fall;
  logic                    w_load;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_bit_next;

  assign w_bck_fall = (div_q == c_DIV_LAST) && bck_q;
  assign w_bit_next = (bit_q == c_LAST_BIT) ? '0 : bit_q + 1'b1;
  assign w_load     = w_bck_fall && (bit_q == c_LAST_BIT);
  assign w_accept   = bus_io.s_valid && ready_q;

  always_comb begin
    div_d      = div_q;
    bck_d      = bck_q;
    ws_d       = ws_q;
    data_d     = data_q;
    bit_d      = bit_q;
    lsh_d      = lsh_q;
    rsh_d      = rsh_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    hold_vld_d = hold_vld_q;
    fs_d       = 1'b0;
    ur_d       = 1'b0;

    if (div_q == c_DIV_LAST) begin
      div_d = '0;
      bck_d = !bck_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    // Everything on the wire moves with the BCK falling edge; WS leads the MSB by one bit.
    if (w_bck_fall) begin
      bit_d  = w_bit_next;
      ws_d   = (w_bit_next >= c_SLOT);
      data_d = 1'b0;
      if (w_load) begin
        fs_d = 1'b1;
        if (hold_vld_q) begin
          lsh_d = hold_l_q;
          rsh_d = hold_r_q;
        end else begin
          lsh_d = '0;
          rsh_d = '0;
          ur_d  = 1'b1;
        end
      end else if (w_bit_next >= c_L_FIRST && w_bit_next <= c_L_LAST) begin
        data_d = lsh_q[SAMPLE_WIDTH-1];
        lsh_d  = lsh_q << 1;
      end else if (w_bit_next >= c_R_FIRST && w_bit_next <= c_R_LAST) begin
        data_d = rsh_q[SAMPLE_WIDTH-1];
        rsh_d  = rsh_q << 1;
      end
    end

    // Accept only happens with the hold empty, so it never collides with a loading frame.
    if (w_accept) begin
      hold_l_d   = bus_io.s_left;
      hold_r_d   = bus_io.s_right;
      hold_vld_d = 1'b1;
    end else if (w_load) begin
      hold_vld_d = 1'b0;
    end

    ready_d = !hold_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      bck_q      <= 1'b0;
      ws_q       <= 1'b0;
      data_q     <= 1'b0;
      bit_q      <= c_LAST_BIT;
      lsh_q      <= '0;
      rsh_q      <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      hold_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      bck_q      <= bck_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      bit_q      <= bit_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      hold_vld_q <= hold_vld_d;
      ready_q    <= ready_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign bus_io.s_ready     = ready_q;
  assign bus_io.i2s_bck     = bck_q;
  assign bus_io.i2s_ws      = ws_q;
  assign bus_io.i2s_data    = data_q;
  assign bus_io.frame_start = fs_q;
  assign bus_io.underrun    = ur_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_tx
// Brief   : Scoreboard bench for i2s_tx (default and narrow-slot instances)
// Revision: 1.0
// ============================================================================
module tb_i2s_tx;

  localparam int SW         = 16;
  localparam int SLOT       = 32;
  localparam int BH         = 4;
  localparam int FRAME_BITS = 2 * SLOT;
  localparam int FRAME_CLK  = FRAME_BITS * 2 * BH;
  localparam int SLOT1      = 17;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset1 = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) bus0 ();
  i2s_tx_if #(.SAMPLE_WIDTH(SW)) bus1 ();

  i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .BCK_HALF(BH)) dut0 (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus0)
  );

  i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT1), .BCK_HALF(1)) dut1 (
    .clk    (clk),
    .reset  (reset1),
    .bus_io (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Expected serial bit at frame position b, straight from the slot layout rules.
  function automatic logic exp_bit(input int b, input logic [SW-1:0] l, input logic [SW-1:0] r);
    if (b >= 1 && b <= SW) return l[SW-b];
    if (b >= SLOT + 1 && b <= SLOT + SW) return r[SW-(b-SLOT)];
    return 1'b0;
  endfunction

  // Cycle count since reset release
  int   n     = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    rst_q <= reset;
    n     <= reset ? 0 : n + 1;
  end

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            cyc;
  } pair_t;
  pair_t pend[$];

  logic          bck_prev = 1'b0;
  bit            in_frame = 1'b0;
  bit            first_fs = 1'b1;
  int            mon_b    = 0;
  int            last_fs  = 0;
  logic [SW-1:0] cur_l    = '0;
  logic [SW-1:0] cur_r    = '0;

  always @(negedge clk) begin
    logic fall;
    logic exp_ur;
    if (rst_q) begin
      check("rst_bck",   bus0.i2s_bck, 0);
      check("rst_ws",    bus0.i2s_ws, 0);
      check("rst_data",  bus0.i2s_data, 0);
      check("rst_fs",    bus0.frame_start, 0);
      check("rst_ur",    bus0.underrun, 0);
      check("rst_ready", bus0.s_ready, 1);
      pend.delete();
      in_frame = 1'b0;
      first_fs = 1'b1;
      mon_b    = 0;
      bck_prev = 1'b0;
    end else begin
      check("bck", bus0.i2s_bck, 64'((n / BH) % 2));
      fall = bck_prev && !bus0.i2s_bck;
      if (bus0.underrun) check("underrun_with_fs", bus0.frame_start, 1);
      if (bus0.frame_start) begin
        check("fs_on_fall", fall, 1);
        if (first_fs) check("first_fs_cycle", n, 2 * BH);
        else          check("frame_period", n - last_fs, FRAME_CLK);
        last_fs  = n;
        first_fs = 1'b0;
        if (pend.size() > 0 && pend[0].cyc < n) begin
          cur_l  = pend[0].l;
          cur_r  = pend[0].r;
          exp_ur = 1'b0;
          void'(pend.pop_front());
        end else begin
          cur_l  = '0;
          cur_r  = '0;
          exp_ur = 1'b1;
        end
        check("underrun", bus0.underrun, exp_ur);
        in_frame = 1'b1;
        mon_b    = 0;
      end else if (fall && in_frame) begin
        mon_b = (mon_b + 1) % FRAME_BITS;
      end
      if (fall && in_frame) begin
        check("ws",   bus0.i2s_ws, (mon_b >= SLOT) ? 1 : 0);
        check("data", bus0.i2s_data, exp_bit(mon_b, cur_l, cur_r));
      end
      check("s_ready", bus0.s_ready, (pend.size() == 0) ? 1 : 0);
      bck_prev = bus0.i2s_bck;
    end
    if (!reset && bus0.s_valid && bus0.s_ready)
      pend.push_back('{bus0.s_left, bus0.s_right, n + 1});
  end

  task automatic send0(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic acc;
    bit   done;
    done          = 1'b0;
    bus0.s_left   = l;
    bus0.s_right  = r;
    bus0.s_valid  = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK + 16 && !done; i++) begin
      @(negedge clk);
      acc = bus0.s_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    bus0.s_valid = 1'b0;
    if (!done) fail_now("send_accept");
  endtask

  initial begin
    logic [SW-1:0]      v;
    logic               acc;
    logic               prev;
    logic               fall1;
    logic [2*SLOT1-1:0] vec;
    int                 b;
    int                 tog_bad;
    bit                 done;

    bus0.s_valid = 1'b0; bus0.s_left = '0; bus0.s_right = '0;
    bus1.s_valid = 1'b0; bus1.s_left = '0; bus1.s_right = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle: every frame underruns with silent data
    repeat (2 * FRAME_CLK + 20) @(posedge clk);
    #1;

    send0(16'hA5F0, 16'h0F5A);
    repeat (2 * FRAME_CLK) @(posedge clk);
    #1;

    // Continuous valid with incrementing samples
    v = 16'h0100;
    bus0.s_left  = v;
    bus0.s_right = ~v;
    bus0.s_valid = 1'b1;
    for (int i = 0; i < 5 * FRAME_CLK; i++) begin
      @(negedge clk);
      acc = bus0.s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        v++;
        bus0.s_left  = v;
        bus0.s_right = ~v;
      end
    end
    bus0.s_valid = 1'b0;

    // Sparse random traffic, occasionally starving the transmitter
    for (int i = 0; i < 8 * FRAME_CLK; i++) begin
      @(posedge clk);
      #1;
      bus0.s_valid = ($urandom_range(0, 299) == 0);
      bus0.s_left  = SW'($urandom);
      bus0.s_right = SW'($urandom);
    end
    bus0.s_valid = 1'b0;

    // Reset mid-frame with the hold register full
    send0(16'h1234, 16'h5678);
    send0(16'hDEAD, 16'hBEEF);
    done = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !done; i++) begin
      @(posedge clk);
      if (mon_b == 20) done = 1'b1;
    end
    if (!done) fail_now("wait_b20");
    check("hold_full_before_reset", bus0.s_ready, 0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * FRAME_CLK + 20) @(posedge clk);
    #1;

    // Narrow instance: BCK every clk, 17-bit slots
    reset1 = 1'b0;
    bus1.s_left  = 16'h8001;
    bus1.s_right = 16'h0000;
    bus1.s_valid = 1'b1;
    @(posedge clk);
    #1 bus1.s_valid = 1'b0;
    @(negedge clk);
    prev    = bus1.i2s_bck;
    vec     = '0;
    b       = -1;
    tog_bad = 0;
    done    = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus1.i2s_bck == prev) tog_bad++;
      fall1 = prev && !bus1.i2s_bck;
      if (fall1) begin
        if (b < 0) begin
          if (bus1.frame_start && !bus1.underrun) b = 0;
        end else begin
          b++;
        end
        if (b >= 0) begin
          vec[b] = bus1.i2s_data;
          if (b == 2 * SLOT1 - 1) done = 1'b1;
        end
      end
      prev = bus1.i2s_bck;
    end
    check("dut1_frame_seen", done, 1);
    check("dut1_bck_every_clk", tog_bad, 0);
    check("dut1_frame_bits", vec, 64'h0_0001_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
